// File: rtl/remote_key_pkg.sv
// Shared types and sizes for the IR remote key scheduler.
package remote_key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_AUTO  = 2'd2
    } key_state_t;

    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = 2;
    localparam int CNT_W      = 3;
    localparam int ENTRY_W    = 9;
    localparam int MS_TMR_W   = 10;

    typedef logic [MS_TMR_W-1:0] ms_tmr_t;

    // Key events are stored as {rpt, code}.
    function automatic logic [ENTRY_W-1:0] pack_entry(input logic rpt, input logic [7:0] code);
        return {rpt, code};
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Four-entry show-ahead key-event FIFO; head is valid whenever empty is low.
import remote_key_pkg::*;

module key_fifo (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic               full,
    output logic               empty,
    output logic [ENTRY_W-1:0] head
);

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem[rd_ptr];

    // Storage array, no reset needed: contents are only visible through count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at the array depth; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/remote_key_sched.sv
// IR remote key scheduler: press/auto-repeat FSM, key-event queue and
// frame-synchronised display update.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | no key held; repeat frames ignored
//   ST_PRESS | key pressed, waiting out the hold delay before auto-repeat
//   ST_AUTO  | auto-repeating every repeat period while repeat frames arrive
import remote_key_pkg::*;

module remote_key_sched #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int HOLD_DLY_MS = 500,
    parameter int RPT_PER_MS  = 100,
    parameter int RELEASE_MS  = 120
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       data_en,
    input  logic [7:0] data,
    input  logic       repeat_en,
    input  logic       frame_sync,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_rpt,
    input  logic       key_ready,
    output logic       key_held,
    output logic [7:0] disp_code,
    output logic       disp_upd,
    output logic       fifo_ovf
);

    localparam int TICK_DIV = CLK_FREQ / 1000;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam ms_tmr_t HOLD_LIM = ms_tmr_t'(HOLD_DLY_MS);
    localparam ms_tmr_t RPT_LIM  = ms_tmr_t'(RPT_PER_MS);
    localparam ms_tmr_t REL_LIM  = ms_tmr_t'(RELEASE_MS);

    key_state_t         state;
    key_state_t         state_nxt;
    logic [PRE_W-1:0]   pre_cnt;
    logic               tick;
    ms_tmr_t            hold_tmr;
    ms_tmr_t            rel_tmr;
    logic [7:0]         code_q;
    logic               push;
    logic               push_rpt;
    logic               hold_clr;
    logic               rel_clr;
    logic [7:0]         push_code;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_head;
    logic               fs_q;
    logic               fs_rise;
    logic               pending;
    logic [7:0]         pend_code;

    assign tick = (pre_cnt == PRE_MAX);

    // Free-running millisecond prescaler.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // FSM state register and latched key code.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state  <= ST_IDLE;
            code_q <= '0;
        end else begin
            state <= state_nxt;
            if (data_en) begin
                code_q <= data;
            end
        end
    end

    // Next state and push decisions: new frame beats release, release beats hold/repeat.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_rpt  = 1'b0;
        hold_clr  = 1'b0;
        rel_clr   = 1'b0;
        if (data_en) begin
            state_nxt = ST_PRESS;
            push      = 1'b1;
            hold_clr  = 1'b1;
            rel_clr   = 1'b1;
        end else begin
            case (state)
                ST_PRESS, ST_AUTO: begin
                    if (rel_tmr >= REL_LIM) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        rel_clr = repeat_en;
                        if (hold_tmr >= ((state == ST_PRESS) ? HOLD_LIM : RPT_LIM)) begin
                            push      = 1'b1;
                            push_rpt  = 1'b1;
                            hold_clr  = 1'b1;
                            state_nxt = ST_AUTO;
                        end
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Millisecond timers; idle and explicit clears override the tick.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hold_tmr <= '0;
            rel_tmr  <= '0;
        end else begin
            if (hold_clr || state_nxt == ST_IDLE) begin
                hold_tmr <= '0;
            end else if (tick && hold_tmr != '1) begin
                hold_tmr <= hold_tmr + 1'b1;
            end
            if (rel_clr || state_nxt == ST_IDLE) begin
                rel_tmr <= '0;
            end else if (tick && rel_tmr != '1) begin
                rel_tmr <= rel_tmr + 1'b1;
            end
        end
    end

    assign push_code = data_en ? data : code_q;
    assign fifo_pop  = ~fifo_empty & key_ready;

    key_fifo u_key_fifo (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .push      (push),
        .push_data (pack_entry(push_rpt, push_code)),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign key_valid = ~fifo_empty;
    assign key_code  = fifo_empty ? 8'h00 : fifo_head[7:0];
    assign key_rpt   = ~fifo_empty & fifo_head[8];
    assign key_held  = (state != ST_IDLE);

    // Sticky overflow: a push into a full queue that is not being drained.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fifo_ovf <= 1'b0;
        end else if (push && fifo_full && !fifo_pop) begin
            fifo_ovf <= 1'b1;
        end
    end

    assign fs_rise = frame_sync & ~fs_q;

    // Display scheduler: remember the latest pushed code, show it on the next vsync rise.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fs_q      <= 1'b0;
            pending   <= 1'b0;
            pend_code <= '0;
            disp_code <= '0;
            disp_upd  <= 1'b0;
        end else begin
            fs_q     <= frame_sync;
            disp_upd <= 1'b0;
            if (fs_rise && (pending || push)) begin
                disp_code <= push ? push_code : pend_code;
                disp_upd  <= 1'b1;
                pending   <= 1'b0;
            end else if (push) begin
                pending   <= 1'b1;
                pend_code <= push_code;
            end
        end
    end

endmodule
